fifo_rd_ctrl: RTL and testbench

- Read-domain controller of the async FIFO.
- Consumes the write pointer after it has been synchronized into the read clock domain (Gray, ADDR_WIDTH+1 bits).
- Maintains the binary and Gray read pointers and drives the dual-port RAM read port.
- Presents data to the consumer through a 2-entry prefetch/skid buffer with valid/ready handshake.
- Exports the Gray read pointer for synchronization back into the write domain.

---
 rtl/fifo_pkg.sv | 33 +++
 rtl/fifo_rd_skid.sv | 92 +++++++++
 rtl/fifo_rd_ctrl.sv | 140 ++++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO constants and pointer helpers
//
// Purpose: default geometry, pointer-width rule and Gray/binary conversion
// shared by the read-side and write-side FIFO controllers.
// The conversion functions work on a fixed FIFO_FN_WIDTH-bit container.
// Callers zero-extend into it and truncate the result back to their own
// pointer width. The container is wide enough for any practical depth.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_FN_WIDTH   = 32;

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [FIFO_FN_WIDTH-1:0] bin2gray(input logic [FIFO_FN_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [FIFO_FN_WIDTH-1:0] gray2bin(input logic [FIFO_FN_WIDTH-1:0] g);
    logic [FIFO_FN_WIDTH-1:0] b;
    b[FIFO_FN_WIDTH-1] = g[FIFO_FN_WIDTH-1];
    for (int i = FIFO_FN_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry prefetch/skid buffer for the FIFO read side
//
// Purpose: holds up to two words fetched from the RAM and presents the head
// to the consumer. A word arriving from the RAM (push) while the buffer is
// empty is bypassed straight to rd_data in its arrival cycle. If it is
// popped in that same cycle it is never stored.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous reset, active-high
//   push       in   RAM read data is valid this cycle
//   push_data  in   RAM read data
//   pop        in   consumer takes rd_data this cycle (already qualified by rd_valid)
//   buf_cnt    out  number of stored words (0..2); excludes the arriving word
//   rd_valid   out  rd_data holds a valid word
//   rd_data    out  head word (stored head, or the arriving word when empty)
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            buf_cnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        // Push together with pop means the bypassed word was consumed.
        if (push && !pop) begin
          head_d = push_data;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d = push_data;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        // A push without a pop cannot occur here: the issue logic never lets
        // stored words plus the word in flight exceed two.
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = push_data;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
      default: begin
        cnt_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign buf_cnt  = cnt_q;
  assign rd_valid = (cnt_q != 2'd0) || push;
  assign rd_data  = (cnt_q != 2'd0) ? head_q : push_data;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read-domain controller
//
// Purpose: keeps the binary and Gray read pointers, derives empty and
// occupancy from the synchronized write pointer, issues RAM reads and feeds
// the fifo_rd_skid prefetch buffer. Depth is 2**ADDR_WIDTH. Pointers are
// ADDR_WIDTH+1 bits wide.
// Optional feature macro: FIFO_RD_ALMOST_EMPTY_EN adds the ralmost_empty
// output, which is high while rlevel <= AE_THRESH.
//
// Ports:
//   rclk           in   read-domain clock
//   rrst           in   synchronous reset, active-high
//   rq2_wptr       in   Gray write pointer, already synchronized to rclk
//   rptr           out  registered Gray read pointer, for the write domain
//   ren            out  RAM read enable; one read per asserted cycle
//   raddr          out  RAM read address
//   rdata_mem      in   RAM read data, valid the cycle after ren
//   rd_valid       out  rd_data holds a valid word
//   rd_ready       in   consumer accepts the word
//   rd_data        out  head-of-buffer word
//   rempty         out  registered; no unfetched words remain in RAM
//   rlevel         out  registered occupancy (unfetched + in flight + buffered)
//   ralmost_empty  out  (FIFO_RD_ALMOST_EMPTY_EN only) registered rlevel <= AE_THRESH
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int AE_THRESH  = 2
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata_mem,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   rlevel
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  output logic                  ralmost_empty
`endif
);

  localparam int PW = ptr_width(ADDR_WIDTH);

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic          rempty_q, rempty_d;
  logic          pending_q, pending_d;

  logic [1:0]    buf_cnt;
  logic [1:0]    occ;
  logic [1:0]    occ_next;
  logic          pop;
  logic [PW-1:0] wbin;

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (rclk),
    .rst       (rrst),
    .push      (pending_q),
    .push_data (rdata_mem),
    .pop       (pop),
    .buf_cnt   (buf_cnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

  assign pop = rd_valid & rd_ready;
  assign occ = buf_cnt + {1'b0, pending_q};

  // A read may be issued while fewer than two words are stored or in flight.
  // At exactly two, a pop in the same cycle frees a slot. This keeps one word
  // per cycle flowing under sustained rd_ready. Reset blocks issue so that
  // no RAM read is started in a cycle whose results would be discarded.
  assign ren = ~rrst & ~rempty_q & ((occ < 2'd2) | ((occ == 2'd2) & pop));

  assign wbin = PW'(gray2bin(FIFO_FN_WIDTH'(rq2_wptr)));

  always_comb begin
    rbin_d    = rbin_q + {{(PW-1){1'b0}}, ren};
    rptr_d    = PW'(bin2gray(FIFO_FN_WIDTH'(rbin_d)));
    // Empty compares all pointer bits, wrap bit included. This separates a
    // full-depth lap from a truly empty FIFO.
    rempty_d  = (rptr_d == rq2_wptr);
    pending_d = ren;
    // Occupancy after this edge: stored words plus arrival, minus pop, plus new issue.
    occ_next  = buf_cnt + {1'b0, pending_q} - {1'b0, pop} + {1'b0, ren};
    // Modular subtraction of the pointers absorbs wrap-around.
    rlevel_d  = (wbin - rbin_d) + PW'(occ_next);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rempty_q  <= 1'b1;
      pending_q <= 1'b0;
      rlevel_q  <= '0;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rempty_q  <= rempty_d;
      pending_q <= pending_d;
      rlevel_q  <= rlevel_d;
    end
  end

  assign rptr   = rptr_q;
  assign raddr  = rbin_q[ADDR_WIDTH-1:0];
  assign rempty = rempty_q;
  assign rlevel = rlevel_q;

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic ralmost_empty_q, ralmost_empty_d;

  // Derived from the next level so that the flag changes on the same edge as rlevel.
  always_comb begin
    ralmost_empty_d = (rlevel_d <= PW'(AE_THRESH));
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      ralmost_empty_q <= 1'b1;
    end else begin
      ralmost_empty_q <= ralmost_empty_d;
    end
  end

  assign ralmost_empty = ralmost_empty_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - scoreboard testbench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic [PW-1:0] rq2_wptr = '0;
  logic [PW-1:0] rptr;
  logic          ren;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata_mem = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rempty;
  logic [PW-1:0] rlevel;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic          ralmost_empty;
`endif

  int errors  = 0;
  int checks  = 0;
  int popped  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem [DEPTH];

  fifo_rd_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .AE_THRESH  (2)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rq2_wptr  (rq2_wptr),
    .rptr      (rptr),
    .ren       (ren),
    .raddr     (raddr),
    .rdata_mem (rdata_mem),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rempty    (rempty),
    .rlevel    (rlevel)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    .ralmost_empty (ralmost_empty)
`endif
  );

  always #5 rclk = ~rclk;

  // RAM model: registered read, data valid the cycle after ren.
  always @(posedge rclk) begin
    if (ren) rdata_mem <= mem[raddr];
  end

  function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [DW-1:0] wval(input int i);
    return DW'(i * 7 + 3);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    rq2_wptr = '0;
    rd_ready = 1'b0;
    exp_q.delete();
    repeat (2) step();
    rrst = 1'b0;
  endtask

  // Monitor: every accepted handshake pops the scoreboard and compares.
  always @(negedge rclk) begin : monitor
    logic [DW-1:0] e;
    if (!rrst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got %0h expected no word", rd_data);
      end else begin
        e = exp_q.pop_front();
        check("pop_data", 32'(rd_data), 32'(e));
      end
      popped++;
    end
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic ae_started = 1'b0;
  always @(posedge rclk) ae_started <= 1'b1;
  always @(negedge rclk) begin
    if (ae_started) check("almost_empty", 32'(ralmost_empty), 32'(rlevel <= PW'(2)));
  end
`endif

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int nren;
    int cyc;
    int wb;
    int rexp;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // Reset with a non-zero write pointer present.
    rrst = 1'b1;
    rq2_wptr = 5'b00110;
    repeat (3) begin
      @(posedge rclk);
      @(negedge rclk);
      check("rst_rptr", 32'(rptr), 32'(0));
      check("rst_rempty", 32'(rempty), 32'(1));
      check("rst_rd_valid", 32'(rd_valid), 32'(0));
      check("rst_rlevel", 32'(rlevel), 32'(0));
      check("rst_ren", 32'(ren), 32'(0));
    end
    do_reset();

    // Single word: two cycles from pointer change to rd_valid.
    mem[0] = 8'hA5;
    exp_q.push_back(8'hA5);
    rd_ready = 1'b1;
    rq2_wptr = 5'b00001;
    @(negedge rclk);
    check("sw_c0_ren", 32'(ren), 32'(0));
    step();
    @(negedge rclk);
    check("sw_c1_ren", 32'(ren), 32'(1));
    check("sw_c1_raddr", 32'(raddr), 32'(0));
    check("sw_c1_rempty", 32'(rempty), 32'(0));
    check("sw_c1_rlevel", 32'(rlevel), 32'(1));
    step();
    @(negedge rclk);
    check("sw_c2_valid", 32'(rd_valid), 32'(1));
    check("sw_c2_data", 32'(rd_data), 32'(8'hA5));
    check("sw_c2_rptr", 32'(rptr), 32'(5'b00001));
    check("sw_c2_rempty", 32'(rempty), 32'(1));
    check("sw_c2_rlevel", 32'(rlevel), 32'(1));
    step();
    @(negedge rclk);
    check("sw_c3_valid", 32'(rd_valid), 32'(0));
    check("sw_c3_rlevel", 32'(rlevel), 32'(0));
    check("sw_drained", 32'(exp_q.size()), 32'(0));

    // Backpressure: four words, consumer stalled.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem[i] = 8'hB0 + 8'(i);
      exp_q.push_back(8'hB0 + 8'(i));
    end
    rq2_wptr = 5'b00110;
    nren = 0;
    repeat (8) begin
      @(negedge rclk);
      if (ren) nren++;
      if (rd_valid) check("bp_hold_data", 32'(rd_data), 32'(8'hB0));
      step();
    end
    @(negedge rclk);
    check("bp_ren_count", 32'(nren), 32'(2));
    check("bp_valid", 32'(rd_valid), 32'(1));
    check("bp_rlevel", 32'(rlevel), 32'(4));
    check("bp_rempty", 32'(rempty), 32'(0));
    step();
    rd_ready = 1'b1;
    repeat (4) begin
      @(negedge rclk);
      check("bp_stream_valid", 32'(rd_valid), 32'(1));
      step();
    end
    @(negedge rclk);
    check("bp_end_valid", 32'(rd_valid), 32'(0));
    check("bp_drained", 32'(exp_q.size()), 32'(0));
    check("bp_end_rlevel", 32'(rlevel), 32'(0));

    // Wrap: 40 words through a 16-deep FIFO with the consumer always ready.
    do_reset();
    rd_ready = 1'b1;
    popped = 0;
    wb = 0;
    rexp = 0;
    cyc = 0;
    while (popped < 40 && cyc < 400) begin
      if (wb < 40 && (wb - popped) < DEPTH) begin
        mem[wb % DEPTH] = wval(wb);
        exp_q.push_back(wval(wb));
        wb++;
        rq2_wptr = gray(PW'(wb));
      end
      @(negedge rclk);
      check("wrap_rptr", 32'(rptr), 32'(gray(PW'(rexp))));
      if (ren) begin
        check("wrap_raddr", 32'(raddr), 32'(rexp % DEPTH));
        check("wrap_ren_not_empty", 32'(rempty), 32'(0));
        rexp++;
      end
      step();
      cyc++;
    end
    check("wrap_popped", 32'(popped), 32'(40));
    check("wrap_reads", 32'(rexp), 32'(40));
    check("wrap_drained", 32'(exp_q.size()), 32'(0));

    // Reset while one word is stored and another is in flight.
    do_reset();
    mem[0] = 8'h55;
    mem[1] = 8'h66;
    rq2_wptr = gray(PW'(2));
    nren = 0;
    cyc = 0;
    while (nren < 2 && cyc < 20) begin
      @(negedge rclk);
      if (ren) nren++;
      step();
      cyc++;
    end
    check("mid_ren_count", 32'(nren), 32'(2));
    rrst = 1'b1;
    exp_q.delete();
    rq2_wptr = '0;
    @(negedge rclk);
    check("mid_pre_data", 32'(rd_data), 32'(8'h55));
    step();
    rrst = 1'b0;
    rd_ready = 1'b1;
    @(negedge rclk);
    check("mid_valid", 32'(rd_valid), 32'(0));
    check("mid_rptr", 32'(rptr), 32'(0));
    check("mid_rempty", 32'(rempty), 32'(1));
    check("mid_rlevel", 32'(rlevel), 32'(0));
    step();
    @(negedge rclk);
    check("mid_no_stale", 32'(rd_valid), 32'(0));
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
